// File: rtl/mdr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdr_pkg
// Description : Shared types for the multiply/divide sequencer: operation
//               encodings and FSM state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package mdr_pkg;

   localparam int OP_W    = 2;
   localparam int STATE_W = 2;

   // Operation codes as seen on the request bus
   typedef enum logic [OP_W-1:0] {
      OP_MUL  = 2'b00,
      OP_DIV  = 2'b01,
      OP_ILL0 = 2'b10,
      OP_ILL1 = 2'b11
   } op_e;

   // Sequencer FSM states
   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage : mdr_pkg
`default_nettype wire

// File: rtl/mdr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mdr_if
// Description : Request/response bus of the multiply/divide sequencer.
//               master = requester, slave = sequencer.
// Revision    : 1.0  initial release
// ============================================================================
interface mdr_if
   import mdr_pkg::*;
#(
   parameter int N = 4
);
   logic           start;
   op_e            op;
   logic [N-1:0]   data_a;
   logic [N-1:0]   data_b;
   logic           ready;
   logic           done;
   logic [2*N-1:0] result;
   logic           error;

   modport master (
      output start, op, data_a, data_b,
      input  ready, done, result, error
   );

   modport slave (
      input  start, op, data_a, data_b,
      output ready, done, result, error
   );

endinterface : mdr_if
`default_nettype wire

// File: rtl/mdr_sequencer_step_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdr_step_unit
// Description : One iteration of the shared datapath. Multiply performs a
//               radix-2 Booth step followed by an arithmetic right shift of
//               {A,Q}; divide performs one restoring-division step.
// Revision    : 1.0  initial release
// ============================================================================
module mdr_step_unit
   import mdr_pkg::*;
#(
   parameter int N = 4
) (
   input  wire logic [N:0]     i_a,   // accumulator, one guard bit
   input  wire logic [N:0]     i_q,   // mul: {multiplier, q_-1}; div: {1'b0, dividend/quotient}
   input  wire logic [N:0]     i_m,   // mul: sign-extended multiplicand; div: zero-extended divisor
   input  wire op_e            i_op,
   output logic      [2*N+1:0] o_aq   // next {A,Q}
);

   logic [N:0] w_sum;
   logic [N:0] w_shl_a;
   logic [N:0] w_trial;

   // Booth add/sub + ASR for multiply, shift/trial-subtract/restore for divide
   always_comb begin
      w_sum   = i_a;
      w_shl_a = {i_a[N-1:0], i_q[N-1]};
      w_trial = w_shl_a - i_m;
      o_aq    = {i_a, i_q};
      if (i_op == OP_MUL) begin
         case (i_q[1:0])
            2'b01:   w_sum = i_a + i_m;
            2'b10:   w_sum = i_a - i_m;
            default: w_sum = i_a;
         endcase
         // Arithmetic right shift of the whole {A,Q} pair
         o_aq = {w_sum[N], w_sum, i_q[N:1]};
      end else begin
         // The remainder never exceeds the divisor, so the shifted value is at
         // most 2M-1 and the trial difference's bit N is a reliable sign.
         if (w_trial[N]) begin
            o_aq = {w_shl_a, 1'b0, i_q[N-2:0], 1'b0};
         end else begin
            o_aq = {w_trial, 1'b0, i_q[N-2:0], 1'b1};
         end
      end
   end

endmodule : mdr_step_unit
`default_nettype wire

// File: rtl/mdr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mdr_sequencer
// Description : Iterative signed-multiply / unsigned-divide sequencer.
//               FSM IDLE->LOAD->RUN(N cycles)->DONE, fixed latency; error
//               ops skip RUN. All outputs are registered.
// Revision    : 1.0  initial release
// ============================================================================
module mdr_sequencer
   import mdr_pkg::*;
#(
   parameter int N = 4
) (
   input  wire logic clk,
   input  wire logic rst_n,
   mdr_if.slave      bus
);

   localparam int CNT_W = $clog2(N + 1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [N-1:0]     opa_q, opa_d;
   logic [N-1:0]     opb_q, opb_d;
   logic [N:0]       a_q, a_d;
   logic [N:0]       q_q, q_d;
   logic [N:0]       m_q, m_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [2*N-1:0]   result_q, result_d;

   logic [2*N+1:0]   w_step_aq;
   logic [N:0]       w_step_a;
   logic [N:0]       w_step_q;
   logic             w_load_err;

   mdr_step_unit #(.N(N)) u_step (
      .i_a  (a_q),
      .i_q  (q_q),
      .i_m  (m_q),
      .i_op (op_q),
      .o_aq (w_step_aq)
   );

   assign w_step_a   = w_step_aq[2*N+1:N+1];
   assign w_step_q   = w_step_aq[N:0];
   assign w_load_err = op_q[1] || ((op_q == OP_DIV) && (opb_q == '0));

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      a_d      = a_q;
      q_d      = q_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      error_d  = error_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d    = bus.op;
               opa_d   = bus.data_a;
               opb_d   = bus.data_b;
               state_d = LOAD;
            end
         end
         LOAD: begin
            a_d   = '0;
            cnt_d = CNT_W'(N);
            if (w_load_err) begin
               error_d  = 1'b1;
               result_d = '0;
               state_d  = DONE;
            end else if (op_q == OP_MUL) begin
               q_d     = {opb_q, 1'b0};
               m_d     = {opa_q[N-1], opa_q};
               state_d = RUN;
            end else begin
               q_d     = {1'b0, opa_q};
               m_d     = {1'b0, opb_q};
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = w_step_a;
            q_d   = w_step_q;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               error_d = 1'b0;
               if (op_q == OP_MUL) begin
                  result_d = {w_step_a[N-1:0], w_step_q[N:1]};
               end else begin
                  result_d = {w_step_a[N-1:0], w_step_q[N-1:0]};
               end
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // DONE lasts exactly one cycle, so done mirrors DONE entry
      ready_d = (state_d == IDLE);
      done_d  = (state_d == DONE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         opa_q    <= '0;
         opb_q    <= '0;
         a_q      <= '0;
         q_q      <= '0;
         m_q      <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         a_q      <= a_d;
         q_q      <= q_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         error_q  <= error_d;
         result_q <= result_d;
      end
   end

   assign bus.ready  = ready_q;
   assign bus.done   = done_q;
   assign bus.error  = error_q;
   assign bus.result = result_q;

endmodule : mdr_sequencer
`default_nettype wire

// File: tb/tb_mdr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdr_sequencer
// Description : Directed self-checking bench for mdr_sequencer, N=4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mdr_sequencer;
   import mdr_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   mdr_if #(.N(N)) bus ();

   mdr_sequencer #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports mismatches
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and check latency, result, error and post-DONE behaviour
   task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] exp_res,
                         input logic exp_err, input int exp_lat);
      int guard;
      int cyc;
      guard = 0;
      while (bus.ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      check({tag, "_ready"}, 32'(bus.ready), 32'd1);
      bus.start  = 1'b1;
      bus.op     = op_e'(op);
      bus.data_a = a;
      bus.data_b = b;
      tick();
      cyc = 1;
      // Inputs changing after acceptance must have no effect
      bus.start  = 1'b0;
      bus.op     = op_e'(~op);
      bus.data_a = ~a;
      bus.data_b = ~b;
      while (bus.done !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
      check({tag, "_error"}, 32'(bus.error), 32'(exp_err));
      // A start during the done cycle must be ignored
      bus.start  = 1'b1;
      bus.op     = OP_MUL;
      bus.data_a = 4'h5;
      bus.data_b = 4'h5;
      tick();
      bus.start = 1'b0;
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
      check({tag, "_result_hold"}, 32'(bus.result), 32'(exp_res));
   endtask

   initial begin
      int pulses;
      bus.start  = 1'b1;   // asserted during reset: must be ignored
      bus.op     = OP_MUL;
      bus.data_a = 4'h3;
      bus.data_b = 4'h3;
      rst_n      = 1'b0;
      tick();
      tick();
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_error", 32'(bus.error), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      bus.start = 1'b0;
      rst_n     = 1'b1;
      tick();
      check("idle_ready", 32'(bus.ready), 32'd1);

      run_op("mul_3xm2",  2'b00, 4'h3, 4'hE, 8'hFA, 1'b0, 6);
      run_op("mul_m8xm8", 2'b00, 4'h8, 4'h8, 8'h40, 1'b0, 6);
      run_op("mul_7xm8",  2'b00, 4'h7, 4'h8, 8'hC8, 1'b0, 6);
      run_op("mul_m1x7",  2'b00, 4'hF, 4'h7, 8'hF9, 1'b0, 6);
      run_op("div_13_3",  2'b01, 4'hD, 4'h3, 8'h14, 1'b0, 6);
      run_op("div_15_1",  2'b01, 4'hF, 4'h1, 8'h0F, 1'b0, 6);
      run_op("div_7_9",   2'b01, 4'h7, 4'h9, 8'h70, 1'b0, 6);
      run_op("div_by0",   2'b01, 4'h5, 4'h0, 8'h00, 1'b1, 2);
      run_op("op_ill10",  2'b10, 4'h3, 4'h2, 8'h00, 1'b1, 2);
      run_op("op_ill11",  2'b11, 4'h3, 4'h2, 8'h00, 1'b1, 2);
      run_op("mul_after_err", 2'b00, 4'h3, 4'hE, 8'hFA, 1'b0, 6);

      // Abort mid-RUN: start pulsed in RUN cycle 1, reset in RUN cycle 2
      bus.start  = 1'b1;
      bus.op     = OP_MUL;
      bus.data_a = 4'h3;
      bus.data_b = 4'hE;
      tick();                // cycle 1: LOAD
      bus.start = 1'b0;
      tick();                // cycle 2: RUN 1
      check("abort_busy", 32'(bus.ready), 32'd0);
      bus.start  = 1'b1;
      bus.data_a = 4'h7;
      bus.data_b = 4'h7;
      tick();                // cycle 3: RUN 2
      bus.start = 1'b0;
      rst_n     = 1'b0;
      bus.start = 1'b1;
      tick();
      check("abort_ready", 32'(bus.ready), 32'd1);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_result", 32'(bus.result), 32'd0);
      rst_n     = 1'b1;
      bus.start = 1'b0;
      pulses    = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done === 1'b1) pulses++;
      end
      check("abort_no_done", 32'(pulses), 32'd0);
      run_op("div_after_abort", 2'b01, 4'hD, 4'h3, 8'h14, 1'b0, 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mdr_sequencer
`default_nettype wire

// File: doc/mdr_sequencer.md
MDR_SEQUENCER -- requirements
Module: mdr_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only while ready=1.
REQ-005 SHALL have port op, input, 2 bits: 2'b00 signed multiply, 2'b01 unsigned divide, 2'b1x illegal.
REQ-006 SHALL have port data_a, input, N bits: multiplicand or dividend.
REQ-007 SHALL have port data_b, input, N bits: multiplier or divisor.
REQ-008 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port result, output, 2N bits: multiply gives the signed product; divide gives {remainder[N-1:0], quotient[N-1:0]}.
REQ-011 SHALL have port error, output, 1 bit: divide-by-zero or illegal op, valid while done=1.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, RUN and DONE.
REQ-013 SHALL move IDLE->LOAD when start=1, capturing op, data_a and data_b into internal registers.
REQ-014 SHALL ignore start and input changes outside IDLE.
REQ-015 LOAD SHALL clear accumulator A, set Q={operand_b,1'b0} for multiply or {dividend} for divide, load M, set the step counter to N, then go to RUN.
REQ-016 LOAD SHALL go directly to DONE with error=1 and result=0 when op=2'b1x, or when op=2'b01 and data_b=0.
REQ-017 Multiply RUN SHALL perform exactly one radix-2 Booth step per cycle: Q[1:0]=01 -> A+M, 10 -> A-M, else A; then arithmetic right shift of {A,Q}.
REQ-018 Divide RUN SHALL perform exactly one restoring step per cycle: shift {A,Q} left, trial A-M; if negative, restore and set Q[0]=0, else keep the difference and set Q[0]=1.
REQ-019 A SHALL be N+1 bits wide so that M=-2^(N-1) and maximum dividends neither overflow nor lose the sign.
REQ-020 The counter SHALL decrement each RUN cycle; RUN->DONE when it reaches 1 on an edge, giving exactly N RUN cycles.
REQ-021 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-022 Latency SHALL be fixed: start sampled at cycle 0 -> done=1 in cycle N+2 for valid ops, and in cycle 2 for error cases.
REQ-023 result and error SHALL be registered, SHALL update only on DONE entry, and SHALL hold until the next DONE.
REQ-024 A start in the same cycle as done=1 SHALL be ignored; it is accepted on the following cycle, when ready=1.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, ready=1, done=0, error=0, result=0, and clear A, Q, M and the counter.
REQ-026 Reset mid-RUN or mid-DONE SHALL abort the operation with no done pulse; ready=1 in the cycle after the reset edge.
REQ-027 A start asserted while rst_n=0 SHALL be ignored.

Structure
REQ-028 Package mdr_pkg SHALL hold the op_e enum (OP_MUL, OP_DIV, OP_ILL0, OP_ILL1) and the state_e enum.
REQ-029 The per-iteration add/sub/shift logic SHALL be one combinational sub-module, mdr_step_unit (inputs: A, Q, M, op; output: next {A,Q}).
REQ-030 The FSM, counter and registers SHALL reside in mdr_sequencer.

Verification (N=4)
REQ-031 op=00, a=3, b=-2 (4'hE) -> done in cycle 6, result=8'hFA, error=0.
REQ-032 op=00, a=-8, b=-8 -> result=8'h40; op=00, a=7, b=-8 -> result=8'hC8.
REQ-033 op=01, a=13, b=3 -> result=8'h14; op=01, a=15, b=1 -> result=8'h0F.
REQ-034 op=01, b=0, or op=2'b10 -> done in cycle 2, error=1, result=8'h00.
REQ-035 start pulsed during RUN, then rst_n=0 at RUN cycle 2 -> no done pulse, ready=1 the next cycle, and the next op completes correctly.
